shift_reg: RTL and testbench

SHIFT_REG -- requirements
Module: shift_reg

---
 rtl/shift_reg.sv | 38 +++
 tb/tb_shift_reg.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_reg.sv
// Serial-in serial-out shift register.
// DEPTH flops in a chain; SI enters stage 0 and leaves on SO from the last stage.
// The reset is synchronous and active-high, and it loads RESET_VAL into every stage.
// There is no enable, so the chain shifts on every edge where reset is not asserted.
module shift_reg #(
    parameter int   DEPTH     = 4,
    parameter logic RESET_VAL = 1'b0
) (
    output logic SO,
    input  logic clk,
    input  logic rst,
    input  logic SI
);

    logic [DEPTH-1:0] stage_q;
    logic [DEPTH-1:0] stage_d;

    // Next chain contents: SI enters at stage 0, and each stage takes its predecessor.
    always_comb begin
        stage_d    = stage_q;
        stage_d[0] = SI;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Stage register: reset has priority over shifting.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= {DEPTH{RESET_VAL}};
        end else begin
            stage_q <= stage_d;
        end
    end

    assign SO = stage_q[DEPTH-1];

endmodule

// File: tb/tb_shift_reg.sv
// Testbench for shift_reg.
// Two instances run side by side: the default configuration (DEPTH=4, RESET_VAL=0)
// and a single-stage instance that resets to 1.
// The reference model keeps a log of the (SI, rst) values sampled at each edge.
// It predicts SO as the SI value sampled DEPTH-1 edges earlier.
// If any reset falls inside that window, the prediction is RESET_VAL instead.
module tb_shift_reg;

    localparam int   D4  = 4;
    localparam logic RV4 = 1'b0;
    localparam int   D1  = 1;
    localparam logic RV1 = 1'b1;

    logic clk;
    logic rst;
    logic SI;
    logic so4;
    logic so1;

    int errors = 0;
    int checks = 0;

    bit si_log[$];
    bit rst_log[$];

    shift_reg #(.DEPTH(D4), .RESET_VAL(RV4)) dut4 (
        .SO (so4),
        .clk(clk),
        .rst(rst),
        .SI (SI)
    );

    shift_reg #(.DEPTH(D1), .RESET_VAL(RV1)) dut1 (
        .SO (so1),
        .clk(clk),
        .rst(rst),
        .SI (SI)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Record what the design sees at every rising edge.
    always @(posedge clk) begin
        si_log.push_back(SI === 1'b1);
        rst_log.push_back(rst === 1'b1);
    end

    function automatic logic model_so(int d, logic rv);
        int n;
        n = si_log.size() - 1;
        if (n - d + 1 < 0) return 1'bx;
        for (int k = n - d + 1; k <= n; k++) begin
            if (rst_log[k]) return rv;
        end
        return logic'(si_log[n - d + 1]);
    endfunction

    // Drive inputs on the falling edge, then return just after the next rising edge.
    task automatic tick(input logic si_v, input logic rst_v);
        @(negedge clk);
        SI  = si_v;
        rst = rst_v;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic exp1;
        tick(1'b1, 1'b1);
        checks++;
        if (so4 !== 1'b0) begin
            errors++;
            $display("FAIL reset_so4: got %b expected 0", so4);
        end
        checks++;
        if (so1 !== RV1) begin
            errors++;
            $display("FAIL reset_so1: got %b expected %b", so1, RV1);
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0);
            checks++;
            if (so4 !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold_%0d: got %b expected 0", i, so4);
            end
        end
        exp1 = model_so(D1, RV1);
        checks++;
        if (so1 !== exp1) begin
            errors++;
            $display("FAIL reset_so1_follow: got %b expected %b", so1, exp1);
        end
    endtask

    task automatic test_latency;
        logic exp4 [1:5];
        exp4 = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tick(1'b0, 1'b1);
        for (int e = 1; e <= 5; e++) begin
            tick((e == 1) ? 1'b1 : 1'b0, 1'b0);
            checks++;
            if (so4 !== exp4[e]) begin
                errors++;
                $display("FAIL latency_edge%0d: got %b expected %b", e, so4, exp4[e]);
            end
            checks++;
            if (so1 !== ((e == 1) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL latency1_edge%0d: got %b expected %b", e, so1, (e == 1));
            end
        end
    endtask

    task automatic test_pattern;
        logic pat [0:6];
        pat = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        tick(1'b0, 1'b1);
        for (int i = 0; i < 7 + D4 - 1; i++) begin
            tick((i < 7) ? pat[i] : 1'b0, 1'b0);
            if (i >= D4 - 1) begin
                checks++;
                if (so4 !== pat[i - (D4 - 1)]) begin
                    errors++;
                    $display("FAIL pattern_%0d: got %b expected %b", i - (D4 - 1), so4, pat[i - (D4 - 1)]);
                end
            end
        end
    endtask

    task automatic test_midstream_reset;
        tick(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0);
        checks++;
        if (so4 !== 1'b1) begin
            errors++;
            $display("FAIL mid_loaded: got %b expected 1", so4);
        end
        tick(1'b1, 1'b1);
        checks++;
        if (so4 !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got %b expected 0", so4);
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0);
            checks++;
            if (so4 !== 1'b0) begin
                errors++;
                $display("FAIL mid_hold_%0d: got %b expected 0", i, so4);
            end
        end
    endtask

    task automatic test_sync_reset_pulse;
        logic held4;
        logic held1;
        logic exp;
        tick(1'b0, 1'b1);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        held4 = so4;
        held1 = so1;
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        checks++;
        if (so4 !== held4 || so1 !== held1) begin
            errors++;
            $display("FAIL rst_pulse_async: got %b/%b expected %b/%b", so4, so1, held4, held1);
        end
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b0);
            exp = model_so(D4, RV4);
            checks++;
            if (so4 !== exp) begin
                errors++;
                $display("FAIL rst_pulse_shift_%0d: got %b expected %b", i, so4, exp);
            end
        end
    endtask

    task automatic test_glitch;
        logic v;
        logic held;
        logic exp4;
        logic exp1;
        for (int i = 0; i < 8; i++) begin
            v = logic'($urandom_range(0, 1));
            @(negedge clk);
            rst = 1'b0;
            SI = ~v;
            #1 SI = v;
            #1 SI = ~v;
            #1 SI = v;
            @(posedge clk);
            #1;
            held = so4;
            SI = ~v;
            #2 SI = v;
            #1 SI = ~v;
            checks++;
            if (so4 !== held) begin
                errors++;
                $display("FAIL glitch_midcycle_%0d: got %b expected %b", i, so4, held);
            end
            exp4 = model_so(D4, RV4);
            exp1 = model_so(D1, RV1);
            checks++;
            if (so4 !== exp4 || so1 !== exp1) begin
                errors++;
                $display("FAIL glitch_%0d: got %b/%b expected %b/%b", i, so4, so1, exp4, exp1);
            end
            checks++;
            if (so1 !== v) begin
                errors++;
                $display("FAIL glitch_d1_%0d: got %b expected %b", i, so1, v);
            end
        end
    endtask

    task automatic test_random;
        logic exp4;
        logic exp1;
        tick(1'b0, 1'b1);
        for (int i = 0; i < 300; i++) begin
            tick(logic'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
            exp4 = model_so(D4, RV4);
            exp1 = model_so(D1, RV1);
            checks++;
            if (so4 !== exp4) begin
                errors++;
                $display("FAIL random4_%0d: got %b expected %b", i, so4, exp4);
            end
            checks++;
            if (so1 !== exp1) begin
                errors++;
                $display("FAIL random1_%0d: got %b expected %b", i, so1, exp1);
            end
        end
    endtask

    initial begin
        SI  = 1'b0;
        rst = 1'b1;
        test_reset();
        test_latency();
        test_pattern();
        test_midstream_reset();
        test_sync_reset_pulse();
        test_glitch();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
